// File: rtl/dds_pkg.sv
`timescale 1ns/1ps
// dds_pkg: wave codes, FSM encoding, event indices and default tuning limits
// shared by the DDS parameter controller (sweep option: DDS_SWEEP_EN).
package dds_pkg;

    localparam logic [3:0] WAVE_SIN = 4'b0001;
    localparam logic [3:0] WAVE_SQU = 4'b0010;
    localparam logic [3:0] WAVE_TRI = 4'b0100;
    localparam logic [3:0] WAVE_SAW = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_OFFER = 2'd2
    } dds_state_t;

    // Pending-bit index doubles as the service priority (lowest index first).
    localparam logic [1:0] EV_WAVE  = 2'd0;
    localparam logic [1:0] EV_FUP   = 2'd1;
    localparam logic [1:0] EV_FDN   = 2'd2;
    localparam logic [1:0] EV_PHASE = 2'd3;

    localparam logic [31:0] DFLT_FW_STEP   = 32'd85_899;
    localparam logic [31:0] DFLT_FW_MIN    = 32'd85_899;
    localparam logic [31:0] DFLT_FW_MAX    = 32'd8_589_900;
    localparam logic [23:0] DFLT_SWEEP_DIV = 24'd4_999_999;

    function automatic logic [1:0] pick_event(input logic [3:0] pend);
        if (pend[EV_WAVE])     return EV_WAVE;
        else if (pend[EV_FUP]) return EV_FUP;
        else if (pend[EV_FDN]) return EV_FDN;
        else                   return EV_PHASE;
    endfunction

endpackage

// File: rtl/dds_sweep_tick.sv
`timescale 1ns/1ps
// dds_sweep_tick: down-counting divider that pulses tick every DIV+1 enabled
// cycles; only instantiated when DDS_SWEEP_EN is defined.
module dds_sweep_tick
    import dds_pkg::*;
#(
    parameter int unsigned      DIV_W = 24,
    parameter logic [DIV_W-1:0] DIV   = DFLT_SWEEP_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en) begin
            cnt <= DIV;
        end else if (cnt == '0) begin
            cnt <= DIV;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/dds_param_ctrl.sv
`timescale 1ns/1ps
// dds_param_ctrl: serialises key events into committed DDS parameter sets.
// Optional frequency sweep generator enabled by defining DDS_SWEEP_EN.
//
// state    | meaning
// ST_IDLE  | wait for a pending event, latch the highest-priority one
// ST_APPLY | update the shadow register for the latched event, clear its bit
// ST_OFFER | cfg_valid high, outputs frozen until cfg_ready
module dds_param_ctrl
    import dds_pkg::*;
#(
`ifdef DDS_SWEEP_EN
    parameter logic [23:0]     SWEEP_DIV = DFLT_SWEEP_DIV,
`endif
    parameter int unsigned     FW_W    = 32,
    parameter int unsigned     PH_W    = 12,
    parameter logic [FW_W-1:0] FW_STEP = DFLT_FW_STEP,
    parameter logic [FW_W-1:0] FW_MIN  = DFLT_FW_MIN,
    parameter logic [FW_W-1:0] FW_MAX  = DFLT_FW_MAX
) (
`ifdef DDS_SWEEP_EN
    input  logic            sweep_on,
`endif
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            evt_wave,
    input  logic            evt_fup,
    input  logic            evt_fdn,
    input  logic            evt_phase,
    output logic [3:0]      wave_select,
    output logic [FW_W-1:0] freq_word,
    output logic [PH_W-1:0] phase_word,
    output logic            cfg_valid,
    input  logic            cfg_ready,
    output logic            busy
);

    localparam logic [PH_W-1:0] PH_QTR = PH_W'(1) << (PH_W - 2);

    dds_state_t      state, state_nxt;
    logic [1:0]      sel, sel_nxt;
    logic [3:0]      pend, pend_set, pend_clr;
    logic            sweep_tick, sweep_wrap;
    logic [FW_W:0]   fup_sum, fdn_floor;
    logic [FW_W-1:0] fup_res, fdn_res;

`ifdef DDS_SWEEP_EN
    logic sweep_src;

    dds_sweep_tick #(.DIV_W(24), .DIV(SWEEP_DIV)) u_sweep_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (sweep_on),
        .tick    (sweep_tick)
    );

    // A key fup merged into a pending sweep fup takes the saturating path.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sweep_src <= 1'b0;
        end else if (evt_fup) begin
            sweep_src <= 1'b0;
        end else if (sweep_tick) begin
            sweep_src <= 1'b1;
        end else if (state == ST_APPLY && sel == EV_FUP) begin
            sweep_src <= 1'b0;
        end
    end

    assign sweep_wrap = sweep_src;
`else
    assign sweep_tick = 1'b0;
    assign sweep_wrap = 1'b0;
`endif

    assign pend_set = {evt_phase, evt_fdn, evt_fup | sweep_tick, evt_wave};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend  <= '0;
            state <= ST_IDLE;
            sel   <= EV_WAVE;
        end else begin
            pend  <= (pend & ~pend_clr) | pend_set;
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        pend_clr  = '0;
        case (state)
            ST_IDLE: begin
                if (|pend) begin
                    sel_nxt   = pick_event(pend);
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                pend_clr[sel] = 1'b1;
                state_nxt     = ST_OFFER;
            end
            ST_OFFER: begin
                if (cfg_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fup_sum   = {1'b0, freq_word} + {1'b0, FW_STEP};
        fdn_floor = {1'b0, FW_MIN} + {1'b0, FW_STEP};
        fup_res   = fup_sum[FW_W-1:0];
        if (fup_sum > {1'b0, FW_MAX}) fup_res = sweep_wrap ? FW_MIN : FW_MAX;
        fdn_res = ({1'b0, freq_word} < fdn_floor) ? FW_MIN : freq_word - FW_STEP;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wave_select <= WAVE_SIN;
            freq_word   <= FW_MIN;
            phase_word  <= '0;
        end else if (state == ST_APPLY) begin
            case (sel)
                EV_WAVE:  wave_select <= {wave_select[2:0], wave_select[3]};
                EV_FUP:   freq_word   <= fup_res;
                EV_FDN:   freq_word   <= fdn_res;
                default:  phase_word  <= phase_word + PH_QTR;
            endcase
        end
    end

    assign cfg_valid = (state == ST_OFFER);
    assign busy      = (state != ST_IDLE) || (|pend);

endmodule

// File: tb/tb_dds_param_ctrl.sv
`timescale 1ns/1ps
// tb_dds_param_ctrl: directed and randomized checks of dds_param_ctrl against
// an arithmetic model of the committed parameter set.
module tb_dds_param_ctrl;

    localparam int STEP = 85_899;
    localparam int FMIN = 85_899;
    localparam int FMAX = 8_589_900;
    localparam int TMO  = 200;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        evt_wave  = 1'b0;
    logic        evt_fup   = 1'b0;
    logic        evt_fdn   = 1'b0;
    logic        evt_phase = 1'b0;
    logic        cfg_ready = 1'b1;
    logic [3:0]  wave_select;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic        cfg_valid;
    logic        busy;

`ifdef DDS_SWEEP_EN
    logic sweep_on = 1'b0;
    dds_param_ctrl #(.SWEEP_DIV(24'd9)) dut (
        .sweep_on    (sweep_on),
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .evt_wave    (evt_wave),
        .evt_fup     (evt_fup),
        .evt_fdn     (evt_fdn),
        .evt_phase   (evt_phase),
        .wave_select (wave_select),
        .freq_word   (freq_word),
        .phase_word  (phase_word),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .busy        (busy)
    );
`else
    dds_param_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .evt_wave    (evt_wave),
        .evt_fup     (evt_fup),
        .evt_fdn     (evt_fdn),
        .evt_phase   (evt_phase),
        .wave_select (wave_select),
        .freq_word   (freq_word),
        .phase_word  (phase_word),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .busy        (busy)
    );
`endif

    always #10 sys_clk = ~sys_clk;

    int total   = 0;
    int bad     = 0;
    int commits = 0;
    int m_wave, m_freq, m_phase;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wave  = 0;
        m_freq  = FMIN;
        m_phase = 0;
    endtask

    task automatic model_apply(input int kind, input bit from_sweep);
        case (kind)
            0: m_wave = (m_wave + 1) % 4;
            1: begin
                if (m_freq + STEP > FMAX) m_freq = from_sweep ? FMIN : FMAX;
                else                      m_freq = m_freq + STEP;
            end
            2: m_freq = (m_freq - STEP < FMIN) ? FMIN : m_freq - STEP;
            default: m_phase = (m_phase + 1024) % 4096;
        endcase
    endtask

    task automatic pulse(input logic [3:0] mask, input int reps);
        for (int r = 0; r < reps; r++) begin
            {evt_phase, evt_fdn, evt_fup, evt_wave} = mask;
            tick();
        end
        {evt_phase, evt_fdn, evt_fup, evt_wave} = 4'b0000;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_wave"},  64'(wave_select), 64'(1 << m_wave));
        check({tag, "_freq"},  64'(freq_word),   64'(m_freq));
        check({tag, "_phase"}, 64'(phase_word),  64'(m_phase));
    endtask

    task automatic expect_commit(input string tag, input bit rnd);
        int n = 0;
        while (!(cfg_valid === 1'b1 && cfg_ready === 1'b1) && n < TMO) begin
            tick();
            n++;
            if (rnd) cfg_ready = 1'($urandom_range(0, 1));
        end
        check({tag, "_commit_seen"}, 64'(n < TMO), 64'd1);
        if (n < TMO) begin
            commits++;
            check_outputs(tag);
        end
        tick();
        cfg_ready = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (cfg_valid !== 1'b1 && n < TMO) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 64'(n < TMO), 64'd1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (3) tick();
        sys_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #(20 * 60_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, vcnt, stable;
        logic [3:0] mask;
        int ph_tab [5];
        ph_tab = '{1024, 2048, 3072, 0, 1024};

        // Reset state
        do_reset();
        check("rst_wave",  64'(wave_select), 64'(4'b0001));
        check("rst_freq",  64'(freq_word),   64'(FMIN));
        check("rst_phase", 64'(phase_word),  64'd0);
        check("rst_valid", 64'(cfg_valid),   64'd0);
        check("rst_busy",  64'(busy),        64'd0);

        // Single wave event: cfg_valid exactly at t+3 for one cycle
        repeat (9) tick();
        pulse(4'b0001, 1);
        tick();
        check("lat_t2_valid", 64'(cfg_valid), 64'd0);
        tick();
        check("lat_t3_valid", 64'(cfg_valid), 64'd1);
        check("lat_t3_wave",  64'(wave_select), 64'(4'b0010));
        check("lat_t3_busy",  64'(busy), 64'd1);
        tick();
        check("lat_t4_valid", 64'(cfg_valid), 64'd0);
        model_apply(0, 0);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            pulse(4'b0001, 1);
            model_apply(0, 0);
            expect_commit("wave_rot", 0);
        end

        // Frequency ramp to saturation
        c0 = commits;
        for (int i = 0; i < 101; i++) begin
            pulse(4'b0010, 1);
            model_apply(1, 0);
            expect_commit("fup", 0);
            repeat (6) tick();
        end
        check("fup_commits", 64'(commits - c0), 64'd101);
        check("fup_sat", 64'(freq_word), 64'(FMAX));

`ifdef DDS_SWEEP_EN
        // Sweep from FW_MAX wraps to FW_MIN
        sweep_on = 1'b1;
        model_apply(1, 1);
        expect_commit("sweep_wrap", 0);
        sweep_on = 1'b0;
        repeat (12) tick();
        check("sweep_off_busy", 64'(busy), 64'd0);
`endif

        // Reset while offering, with fdn pending
        cfg_ready = 1'b0;
        pulse(4'b0001, 1);
        wait_valid("rstoffer");
        pulse(4'b0100, 1);
        check("rstoffer_busy_pre", 64'(busy), 64'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        model_reset();
        check("rstoffer_valid", 64'(cfg_valid), 64'd0);
        check("rstoffer_busy",  64'(busy), 64'd0);
        check_outputs("rstoffer");
        cfg_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_valid === 1'b1) vcnt++;
        end
        check("rstoffer_no_commit", 64'(vcnt), 64'd0);

        // fup and phase together under a 20-cycle stall
        cfg_ready = 1'b0;
        pulse(4'b1010, 1);
        model_apply(1, 0);
        wait_valid("stall");
        check("stall_freq",  64'(freq_word),  64'd171_798);
        check("stall_phase", 64'(phase_word), 64'd0);
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_valid === 1'b1 && freq_word === 32'(m_freq) &&
                phase_word === 12'(m_phase) && wave_select === 4'(1 << m_wave)) stable++;
        end
        check("stall_stable", 64'(stable), 64'd20);
        cfg_ready = 1'b1;
        expect_commit("stall_first", 0);
        model_apply(3, 0);
        expect_commit("stall_second", 0);
        check("stall_second_phase", 64'(phase_word), 64'd1024);

        // Phase wrap sequence
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(4'b1000, 1);
            model_apply(3, 0);
            expect_commit("phase", 0);
            check("phase_tab", 64'(phase_word), 64'(ph_tab[i]));
        end

        // Random event bursts with random backpressure
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(1, 15));
            pulse(mask, int'($urandom_range(1, 2)));
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    model_apply(k, 0);
                    expect_commit("rnd", 1);
                end
            end
            repeat (3) tick();
            check("rnd_idle_busy",  64'(busy), 64'd0);
            check("rnd_idle_valid", 64'(cfg_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
